// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive ends of the divider link.
package uart_pkg;

    // 50 MHz system clock / 9600 baud
    localparam int CLK_DIV_DEFAULT = 5208;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter. A push is honoured only when the
// FIFO is not full on the pre-pop count, so a push that coincides with a pop
// while full is still dropped. DEPTH must be a power of two, at least 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrap naturally modulo DEPTH) and count
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed through a small byte FIFO.
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | line high, waiting for a queued byte
// ST_START | start bit (0) on the line
// ST_DATA  | data bits, LSB first, bit index in idx_q
// ST_STOP  | stop bit(s) (1); byte_done on the final cycle
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_ready,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow,
    output logic       byte_done
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST  = IDX_W'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 txd_q, txd_d;
    logic                 overflow_q, overflow_d;
    logic                 byte_done_q, byte_done_d;
    logic                 pop;
    logic                 fifo_empty;
    logic [7:0]           fifo_rd_data;
    logic                 bit_end;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_ready),
        .wr_data (tx_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bit_end   = (cnt_q == CNT_LAST);
    assign txd       = txd_q;
    assign overflow  = overflow_q;
    assign byte_done = byte_done_q;
    assign busy      = (state_q != ST_IDLE) | ~fifo_empty;

    // Next state, baud counter, shifter and registered-output values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        pop         = 1'b0;
        overflow_d  = overflow_q | (tx_ready & fifo_full);
        txd_d       = 1'b1;
        byte_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (idx_q != STOP_LAST) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (!fifo_empty) begin
                        // next frame starts with no idle gap
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered, so they are derived from the next state
        case (state_d)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_d[0];
            default:  txd_d = 1'b1;
        endcase
        byte_done_d = (state_d == ST_STOP) && (cnt_d == CNT_LAST) && (idx_d == STOP_LAST);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            txd_q       <= 1'b1;
            overflow_q  <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            txd_q       <= txd_d;
            overflow_q  <= overflow_d;
            byte_done_q <= byte_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with CLK_DIV=4, depth 4. An independent 8N1 line
// decoder turns txd back into bytes; tests compare against expected queues.
module tb_uart_tx_fifo;

    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int FRAME   = 10 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       txd, busy, fifo_full, overflow, byte_done;

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .txd       (txd),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .byte_done (byte_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int rst_cnt = 0;
    int bd_cnt = 0;
    int framing_err = 0;
    logic [7:0] rx_q[$];
    int start_q[$];
    logic [7:0] exp_q[$];

    typedef struct {
        int   cyc;
        logic txd;
        logic busy;
        logic bd;
    } vec_t;
    vec_t tbl[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rst_cnt <= rst_cnt + 1;
    end

    always @(negedge clk) begin
        if (byte_done === 1'b1) bd_cnt <= bd_cnt + 1;
    end

    // Reference 8N1 decoder: samples mid-bit, discards frames cut by reset
    initial begin : decoder
        int rs;
        logic [7:0] b;
        logic ok;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                rs = rst_cnt;
                start_q.push_back(cyc);
                repeat (CLK_DIV / 2) @(negedge clk);
                ok = (txd === 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    b[i] = txd;
                end
                repeat (CLK_DIV) @(negedge clk);
                ok = ok & (txd === 1'b1);
                if (rs == rst_cnt) begin
                    rx_q.push_back(b);
                    if (!ok) framing_err++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tx_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        rx_q.delete();
        start_q.delete();
        framing_err = 0;
        bd_cnt = 0;
    endtask

    task automatic wait_rel(input int rel);
        while (cyc - t0 < rel) tick();
    endtask

    task automatic push_bytes(input logic [7:0] bytes[$]);
        foreach (bytes[i]) begin
            tx_ready = 1'b1;
            tx_data  = bytes[i];
            tick();
        end
        tx_ready = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
        repeat (CLK_DIV) tick();
    endtask

    task automatic chk_rx(input string name);
        chk({name, "_rx_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk({name, "_rx_byte"}, rx_q[i], exp_q[i]);
        chk({name, "_framing"}, framing_err, 0);
    endtask

    initial begin
        // ---- reset values ----
        rst = 1'b1;
        tick();
        tick();
        t0 = cyc;
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_byte_done", byte_done, 1'b0);
        do_reset();

        // ---- single byte 0x55: table of line checkpoints ----
        tbl.push_back('{1,  1'b1, 1'b1, 1'b0});
        tbl.push_back('{2,  1'b0, 1'b1, 1'b0});
        tbl.push_back('{5,  1'b0, 1'b1, 1'b0});
        tbl.push_back('{6,  1'b1, 1'b1, 1'b0});
        tbl.push_back('{10, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{14, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{18, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{22, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{26, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{30, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{34, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{37, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{38, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{40, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{41, 1'b1, 1'b1, 1'b1});
        tbl.push_back('{42, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{45, 1'b1, 1'b0, 1'b0});
        t0 = cyc;
        tx_ready = 1'b1;
        tx_data  = 8'h55;
        tick();
        tx_ready = 1'b0;
        foreach (tbl[i]) begin
            wait_rel(tbl[i].cyc);
            chk("single_txd", txd, tbl[i].txd);
            chk("single_busy", busy, tbl[i].busy);
            chk("single_byte_done", byte_done, tbl[i].bd);
        end
        repeat (CLK_DIV) tick();
        chk("single_bd_count", bd_cnt, 1);
        exp_q = '{8'h55};
        chk_rx("single");

        // ---- 4-byte response, back to back ----
        do_reset();
        t0 = cyc;
        exp_q = '{8'h34, 8'h12, 8'h07, 8'h00};
        push_bytes(exp_q);
        wait_rel(4 * FRAME + 1);
        chk("resp_last_byte_done", byte_done, 1'b1);
        chk("resp_busy_before_end", busy, 1'b1);
        tick();
        chk("resp_busy_after_end", busy, 1'b0);
        repeat (CLK_DIV) tick();
        chk("resp_start_count", start_q.size(), 4);
        if (start_q.size() == 4) begin
            chk("resp_first_start", start_q[0] - t0, 2);
            for (int i = 0; i < 3; i++)
                chk("resp_frame_spacing", start_q[i+1] - start_q[i], FRAME);
        end
        chk("resp_bd_count", bd_cnt, 4);
        chk("resp_overflow", overflow, 1'b0);
        chk_rx("resp");

        // ---- overflow: six strobes into depth 4 ----
        do_reset();
        t0 = cyc;
        for (int i = 0; i < 6; i++) begin
            tx_ready = 1'b1;
            tx_data  = 8'hA0 + 8'(i);
            tick();
            if (i == 4) begin
                chk("ovf_full_at5", fifo_full, 1'b1);
                chk("ovf_clear_at5", overflow, 1'b0);
            end
            if (i == 5) chk("ovf_set_at6", overflow, 1'b1);
        end
        tx_ready = 1'b0;
        wait_idle(8 * FRAME);
        chk("ovf_sticky", overflow, 1'b1);
        exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        chk_rx("ovf");

        // ---- push while full coinciding with STOP-end pop ----
        do_reset();
        t0 = cyc;
        exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        push_bytes(exp_q);
        chk("pp_full", fifo_full, 1'b1);
        chk("pp_no_ovf", overflow, 1'b0);
        wait_rel(FRAME + 1);
        chk("pp_stop_end", byte_done, 1'b1);
        tx_ready = 1'b1;
        tx_data  = 8'hEE;
        tick();
        tx_ready = 1'b0;
        chk("pp_ovf_set", overflow, 1'b1);
        chk("pp_count_3", fifo_full, 1'b0);
        chk("pp_next_start", txd, 1'b0);
        wait_idle(8 * FRAME);
        chk_rx("pp");

        // ---- reset during data bit 3 of 0xFF with two queued ----
        do_reset();
        t0 = cyc;
        exp_q = '{8'hFF, 8'h11, 8'h22};
        push_bytes(exp_q);
        wait_rel(19);
        chk("mid_busy_before", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_txd", txd, 1'b1);
        chk("mid_busy", busy, 1'b0);
        chk("mid_full", fifo_full, 1'b0);
        chk("mid_byte_done", byte_done, 1'b0);
        begin
            int lows = 0;
            for (int i = 0; i < 3 * FRAME; i++) begin
                tick();
                if (txd !== 1'b1 || busy !== 1'b0) lows++;
            end
            chk("mid_line_quiet", lows, 0);
        end
        chk("mid_bd_count", bd_cnt, 0);
        chk("mid_rx_none", rx_q.size(), 0);

        // ---- random bytes in groups of three: pointer wrap ----
        do_reset();
        t0 = cyc;
        exp_q.delete();
        for (int g = 0; g < 4; g++) begin
            for (int j = 0; j < 3; j++) begin
                logic [7:0] b;
                b = 8'($urandom);
                exp_q.push_back(b);
                tx_ready = 1'b1;
                tx_data  = b;
                tick();
            end
            tx_ready = 1'b0;
            repeat ($urandom_range(80, 200)) tick();
        end
        wait_idle(8 * FRAME);
        chk("wrap_overflow", overflow, 1'b0);
        chk("wrap_bd_count", bd_cnt, 12);
        chk_rx("wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
